// File: rtl/tk1_spi_flash_reader_pkg.sv
// Shared constants, state encoding and header byte selection
// for the tk1 SPI flash READ sequencer.
package tk1_spi_flash_reader_pkg;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;
    localparam logic [7:0] FLASH_DUMMY    = 8'h00;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_SS_ON     = 4'd1,
        ST_LOAD      = 4'd2,
        ST_START     = 4'd3,
        ST_WAIT_BUSY = 4'd4,
        ST_WAIT_DONE = 4'd5,
        ST_NEXT      = 4'd6,
        ST_OUT       = 4'd7,
        ST_SS_OFF    = 4'd8,
        ST_DONE      = 4'd9
    } state_e;

    // Index 0 is the command, 1..3 the address MSB first, 4 the data phase.
    function automatic logic [7:0] hdr_byte(
        input logic [2:0]  idx,
        input logic [23:0] addr,
        input logic [7:0]  cmd
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = cmd;
            3'd1:    b = addr[23:16];
            3'd2:    b = addr[15:8];
            3'd3:    b = addr[7:0];
            default: b = FLASH_DUMMY;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/tk1_spi_flash_reader.sv
// Drives tk1_spi_master through one W25Q80DV READ per request:
// SS on, cmd + 24-bit address, len dummy bytes, stream rx bytes out.
module tk1_spi_flash_reader
    import tk1_spi_flash_reader_pkg::*;
#(
    parameter logic [7:0] CMD_READ = FLASH_CMD_READ,
    parameter int         LEN_W    = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [23:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [7:0]       rd_data,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic             spi_enable,
    output logic             spi_enable_vld,
    output logic             spi_start,
    output logic [7:0]       spi_tx_data,
    output logic             spi_tx_data_vld,
    input  logic [7:0]       spi_rx_data,
    input  logic             spi_ready
);

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [23:0]      addr_q, addr_d;
    logic             abort_q, abort_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_vld_q, rd_vld_d;
    logic             en_q, en_d;
    logic             en_vld_q, en_vld_d;
    logic             start_q, start_d;
    logic [7:0]       tx_q, tx_d;
    logic             tx_vld_q, tx_vld_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rem_d     = rem_q;
        addr_d    = addr_q;
        abort_d   = abort_q;
        busy_d    = busy_q;
        rd_data_d = rd_data_q;
        rd_vld_d  = rd_vld_q;
        en_d      = en_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        en_vld_d  = 1'b0;
        start_d   = 1'b0;
        tx_vld_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    busy_d  = 1'b1;
                    addr_d  = req_addr;
                    rem_d   = req_len;
                    idx_d   = 3'd0;
                    abort_d = 1'b0;
                    if (req_len == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = ST_SS_ON;
                        en_d     = 1'b1;
                        en_vld_d = 1'b1;
                    end
                end
            end
            ST_SS_ON, ST_LOAD: begin
                if (abort) begin
                    state_d  = ST_SS_OFF;
                    en_d     = 1'b0;
                    en_vld_d = 1'b1;
                end else if (state_q == ST_SS_ON) begin
                    state_d  = ST_LOAD;
                    tx_d     = hdr_byte(idx_q, addr_q, CMD_READ);
                    tx_vld_d = 1'b1;
                end else if (spi_ready) begin
                    state_d = ST_START;
                    start_d = 1'b1;
                end
            end
            // A started byte is always allowed to finish before SS drops.
            ST_START: begin
                abort_d = abort_q | abort;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                abort_d = abort_q | abort;
                if (!spi_ready) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                abort_d = abort_q | abort;
                if (spi_ready) begin
                    if (abort_q | abort) begin
                        state_d  = ST_SS_OFF;
                        en_d     = 1'b0;
                        en_vld_d = 1'b1;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                if (abort) begin
                    state_d  = ST_SS_OFF;
                    en_d     = 1'b0;
                    en_vld_d = 1'b1;
                end else if (idx_q != 3'd4) begin
                    idx_d    = idx_q + 3'd1;
                    state_d  = ST_LOAD;
                    tx_d     = hdr_byte(idx_q + 3'd1, addr_q, CMD_READ);
                    tx_vld_d = 1'b1;
                end else begin
                    state_d   = ST_OUT;
                    rd_data_d = spi_rx_data;
                    rd_vld_d  = 1'b1;
                end
            end
            ST_OUT: begin
                if (abort) begin
                    rd_vld_d = 1'b0;
                    state_d  = ST_SS_OFF;
                    en_d     = 1'b0;
                    en_vld_d = 1'b1;
                end else if (rd_rdy) begin
                    rd_vld_d = 1'b0;
                    if (rem_q != '0) rem_d = rem_q - LEN_W'(1);
                    if (rem_q > LEN_W'(1)) begin
                        state_d  = ST_LOAD;
                        tx_d     = FLASH_DUMMY;
                        tx_vld_d = 1'b1;
                    end else begin
                        state_d  = ST_SS_OFF;
                        en_d     = 1'b0;
                        en_vld_d = 1'b1;
                    end
                end
            end
            ST_SS_OFF: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                abort_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            rem_q     <= '0;
            addr_q    <= '0;
            abort_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
            en_q      <= 1'b0;
            en_vld_q  <= 1'b0;
            start_q   <= 1'b0;
            tx_q      <= '0;
            tx_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rem_q     <= rem_d;
            addr_q    <= addr_d;
            abort_q   <= abort_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
            en_q      <= en_d;
            en_vld_q  <= en_vld_d;
            start_q   <= start_d;
            tx_q      <= tx_d;
            tx_vld_q  <= tx_vld_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign rd_data         = rd_data_q;
    assign rd_vld          = rd_vld_q;
    assign spi_enable      = en_q;
    assign spi_enable_vld  = en_vld_q;
    assign spi_start       = start_q;
    assign spi_tx_data     = tx_q;
    assign spi_tx_data_vld = tx_vld_q;

endmodule

// File: tb/tb_tk1_spi_flash_reader.sv
// Bench for tk1_spi_flash_reader with a behavioural SPI master
// and W25Q80DV READ model (mem[a] = a[7:0] ^ 8'h5A).
module tb_tk1_spi_flash_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [23:0] req_addr = '0;
    logic [11:0] req_len = '0;
    logic        abort = 1'b0;
    logic        busy, done, rd_vld;
    logic [7:0]  rd_data;
    logic        rd_rdy = 1'b0;
    logic        spi_enable, spi_enable_vld, spi_start, spi_tx_data_vld;
    logic [7:0]  spi_tx_data;
    logic [7:0]  spi_rx_data;
    logic        spi_ready;

    always #5 clk = ~clk;

    tk1_spi_flash_reader dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
        .req_len(req_len), .abort(abort), .busy(busy), .done(done),
        .rd_data(rd_data), .rd_vld(rd_vld), .rd_rdy(rd_rdy),
        .spi_enable(spi_enable), .spi_enable_vld(spi_enable_vld),
        .spi_start(spi_start), .spi_tx_data(spi_tx_data),
        .spi_tx_data_vld(spi_tx_data_vld), .spi_rx_data(spi_rx_data),
        .spi_ready(spi_ready)
    );

    int n_assert = 0;
    int n_fail = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Master + flash model
    logic [7:0]  txb = '0;
    logic [7:0]  pend = '0;
    logic [23:0] f_addr = '0;
    logic        ss_on = 1'b0;
    int          lat = 0;
    int          lat_max = 3;
    int          sess_k = 0;
    int          n_start = 0;
    int          n_ss_tog = 0;
    int          n_bad_start = 0;
    logic [7:0]  mosi_q[$];

    always @(posedge clk) begin
        if (reset) begin
            spi_ready   <= 1'b1;
            spi_rx_data <= 8'h00;
            lat    = 0;
            sess_k = 0;
            ss_on  = 1'b0;
        end else begin
            if (spi_enable_vld) begin
                ss_on  = spi_enable;
                sess_k = 0;
                n_ss_tog++;
            end
            if (spi_ready) begin
                if (spi_tx_data_vld) txb = spi_tx_data;
                if (spi_start) begin
                    spi_ready <= 1'b0;
                    lat = $urandom_range(lat_max, 1);
                    n_start++;
                    mosi_q.push_back(txb);
                    if (!ss_on || rd_vld) n_bad_start++;
                    if (sess_k < 4) begin
                        f_addr = {f_addr[15:0], txb};
                        pend = 8'hFF;
                    end else begin
                        pend = f_addr[7:0] ^ 8'h5A;
                        f_addr = f_addr + 24'd1;
                    end
                    sess_k++;
                end
            end else begin
                if (spi_start) n_bad_start++;
                lat--;
                if (lat == 0) begin
                    spi_ready   <= 1'b1;
                    spi_rx_data <= pend;
                end
            end
        end
    end

    // Consumer and output monitor
    int         rdy_mode = 0;
    int         stall_left = 0;
    int         n_done = 0;
    int         n_unstable = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] last_rd = '0;
    logic [7:0] got_q[$];

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: rd_rdy = 1'b1;
            1: rd_rdy = ($urandom_range(2, 0) == 0);
            default: begin
                if (stall_left > 0) begin
                    rd_rdy = 1'b0;
                    if (rd_vld) stall_left--;
                end else begin
                    rd_rdy = 1'b1;
                end
            end
        endcase
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (done) n_done++;
            if (prev_hold && rd_vld && rd_data !== last_rd) n_unstable++;
            if (rd_vld && rd_rdy) got_q.push_back(rd_data);
            prev_hold = rd_vld && !rd_rdy;
            last_rd = rd_data;
        end
    end

    task automatic clear_counts();
        n_start = 0; n_ss_tog = 0; n_bad_start = 0;
        n_done = 0; n_unstable = 0;
        mosi_q.delete();
        got_q.delete();
    endtask

    task automatic wait_done(input string tag, input int dup);
        int cyc;
        cyc = 0;
        while (n_done == 0 && cyc < 60000) begin
            @(negedge clk);
            req = (cyc == dup);
            req_addr = ~req_addr;
            req_len = 12'd5;
            abort = 1'b0;
            cyc++;
        end
        req = 1'b0;
        check({tag, " timeout"}, cyc < 60000, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_req(input string tag, input logic [23:0] a,
                           input int len, input bit abt, input int dup);
        logic [7:0] exp_mosi[$];
        int bad_m, bad_d;
        clear_counts();
        @(negedge clk);
        req = 1'b1; req_addr = a; req_len = 12'(len); abort = abt;
        wait_done(tag, dup);
        if (len > 0) begin
            exp_mosi.push_back(8'h03);
            exp_mosi.push_back(a[23:16]);
            exp_mosi.push_back(a[15:8]);
            exp_mosi.push_back(a[7:0]);
            for (int i = 0; i < len; i++) exp_mosi.push_back(8'h00);
        end
        bad_m = 0;
        for (int i = 0; i < mosi_q.size() && i < exp_mosi.size(); i++)
            if (mosi_q[i] !== exp_mosi[i]) bad_m++;
        bad_d = 0;
        for (int i = 0; i < got_q.size(); i++)
            if (got_q[i] !== (8'(a + 24'(i)) ^ 8'h5A)) bad_d++;
        check({tag, " done_count"}, n_done, 1);
        check({tag, " busy_after"}, busy, 0);
        check({tag, " ss_after"}, spi_enable, 0);
        check({tag, " ss_toggles"}, n_ss_tog, len > 0 ? 2 : 0);
        check({tag, " starts"}, n_start, len > 0 ? len + 4 : 0);
        check({tag, " bad_starts"}, n_bad_start, 0);
        check({tag, " mosi_count"}, mosi_q.size(), exp_mosi.size());
        check({tag, " mosi_bytes"}, bad_m, 0);
        check({tag, " data_count"}, got_q.size(), len);
        check({tag, " data_bytes"}, bad_d, 0);
        check({tag, " rd_stable"}, n_unstable, 0);
    endtask

    initial begin
        logic [23:0] a;
        int c;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {busy, done, rd_data, rd_vld, spi_enable, spi_enable_vld,
               spi_start, spi_tx_data, spi_tx_data_vld}, 0);
        reset = 1'b0;
        @(negedge clk);

        // abort while idle is ignored
        clear_counts();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_abort busy", busy, 0);
        check("idle_abort done", n_done, 0);

        rdy_mode = 0;
        run_req("t1", 24'h012345, 4, 1'b0, -1);
        run_req("t2_len0", $urandom, 0, 1'b0, -1);

        rdy_mode = 2; stall_left = 100;
        run_req("t3_stall", $urandom, 3, 1'b0, -1);

        rdy_mode = 1;
        for (int k = 0; k < 4; k++) begin
            lat_max = $urandom_range(4, 1);
            run_req("rand", $urandom, $urandom_range(20, 1), k == 0, 10);
        end

        // abort while the second data byte is on the wire
        rdy_mode = 0; lat_max = 3;
        clear_counts();
        a = $urandom;
        @(negedge clk);
        req = 1'b1; req_addr = a; req_len = 12'd8;
        @(negedge clk);
        req = 1'b0;
        c = 0;
        while (n_start < 6 && c < 2000) begin @(negedge clk); c++; end
        check("t4 reach_byte", n_start, 6);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done("t4", -1);
        check("t4 data_count", got_q.size(), 1);
        check("t4 data0", got_q.size() > 0 ? got_q[0] : 8'hxx, a[7:0] ^ 8'h5A);
        check("t4 starts", n_start, 6);
        check("t4 done_count", n_done, 1);
        check("t4 ss_after", spi_enable, 0);
        check("t4 busy_after", busy, 0);

        // reset in the middle of the header
        clear_counts();
        @(negedge clk);
        req = 1'b1; req_addr = $urandom; req_len = 12'd4;
        @(negedge clk);
        req = 1'b0;
        c = 0;
        while (n_start < 2 && c < 2000) begin @(negedge clk); c++; end
        check("t5 reach_hdr", n_start, 2);
        reset = 1'b1;
        @(negedge clk);
        check("t5 reset_outputs",
              {busy, done, rd_data, rd_vld, spi_enable, spi_enable_vld,
               spi_start, spi_tx_data, spi_tx_data_vld}, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("t5 no_done", n_done, 0);
        check("t5 idle", busy, 0);

        lat_max = 1;
        run_req("t6_max", 24'h0FFFFF - 24'($urandom_range(64, 0)), 4095, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
